// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM states, reset vector and pipeline payload types.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef logic [31:0] InstAddr_t;

  typedef enum logic [2:0] {
    S_RST,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } FetchState_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mm;
    logic stall_wb;
  } Stall_t;

  typedef struct packed {
    logic [31:0] inst2;
    logic [31:0] inst1;
  } InstPair_t;

  typedef struct packed {
    logic iaddr_miss;
  } ExceptInfo_t;

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection for the fetch stage plus the pending-redirect register used
// while an in-flight bus transaction has to be drained.
module if_pc_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              capture_i,
  input  logic              clear_i,
  output logic              redir_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic              pend_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] seq_pc;

  // Priority: flush, then branch, then a stored redirect, then sequential.
  // An upper-word fetch only yields one instruction, so it advances by 4.
  always_comb begin
    redir_o   = flush_i | branch_valid_i;
    redir_pc  = flush_i ? flush_pc_i : branch_target_i;
    seq_pc    = pc_i + (pc_i[2] ? ADDR_W'(4) : ADDR_W'(8));
    next_pc_o = seq_pc;
    if (redir_o) begin
      next_pc_o = redir_pc;
    end else if (pend_q) begin
      next_pc_o = pend_pc_q;
    end
  end

  // Remember a redirect that arrived while the bus was busy; newest one wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (capture_i) begin
      pend_q    <= 1'b1;
      pend_pc_q <= redir_pc;
    end else if (clear_i) begin
      pend_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC sequencing, instruction-bus handshake and the
// registered IF/ID payload (instruction pair, PC, delay-slot/exception/irq tags).
module if_fetch
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [63:0]       ibus_rdata,
  input  Stall_t            stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              next_delayslot,
  input  logic [7:0]        int_flag,
  output logic              stall_req_if,
  output logic [ADDR_W-1:0] if_pc,
  output InstPair_t         if_inst_pair,
  output logic              if_inst2_avail,
  output logic              if_delayslot,
  output ExceptInfo_t       if_except,
  output logic [7:0]        if_interrupt_flag,
  output logic              is_hard_reset
);

  FetchState_t       state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q, stall_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] if_pc_q;
  InstPair_t         pair_q;
  logic              avail_q, ds_out_q, hard_q;
  ExceptInfo_t       except_q;
  logic [7:0]        intr_q;
  logic              first_q, ds_q, flush_seen_q;
  logic [7:0]        int_q;

  logic              redir;
  logic [ADDR_W-1:0] next_pc;
  logic              capture, clear;
  logic              unused_stall;

  // Only the IF bit of the stall vector matters here.
  assign unused_stall = ^{stall.stall_id, stall.stall_ex, stall.stall_mm, stall.stall_wb};

  // Store a redirect while a request is outstanding; release it when that ack drains.
  assign capture = (state_q == S_WAIT || state_q == S_DISCARD) && !ibus_ack && redir;
  assign clear   = (state_q == S_DISCARD) && ibus_ack;

  if_pc_gen #(.ADDR_W(ADDR_W)) u_pc_gen (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_q),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .branch_valid_i  (branch_valid),
    .branch_target_i (branch_target),
    .capture_i       (capture),
    .clear_i         (clear),
    .redir_o         (redir),
    .next_pc_o       (next_pc)
  );

  // Fetch FSM with all bus and pipeline outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RST;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      stall_req_q  <= 1'b0;
      addr_q       <= '0;
      if_pc_q      <= '0;
      pair_q       <= '0;
      avail_q      <= 1'b1;
      ds_out_q     <= 1'b0;
      except_q     <= '0;
      intr_q       <= '0;
      hard_q       <= 1'b1;
      first_q      <= 1'b1;
      ds_q         <= 1'b0;
      int_q        <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_RST: state_q <= S_ISSUE;
        S_ISSUE: begin
          if (redir) begin
            pc_q     <= next_pc;
            if_pc_q  <= '0;
            pair_q   <= '0;
            avail_q  <= 1'b0;
            ds_out_q <= 1'b0;
            except_q <= '0;
            intr_q   <= '0;
          end else if (pc_q[1:0] != 2'b00) begin
            // Misaligned PC: hand an exception-tagged empty pair downstream.
            if_pc_q             <= pc_q;
            pair_q              <= '0;
            avail_q             <= 1'b0;
            ds_out_q            <= next_delayslot & ~flush_seen_q;
            except_q.iaddr_miss <= 1'b1;
            intr_q              <= int_flag;
            hard_q              <= first_q;
            first_q             <= 1'b0;
            flush_seen_q        <= 1'b0;
          end else begin
            req_q       <= 1'b1;
            stall_req_q <= 1'b1;
            addr_q      <= {pc_q[ADDR_W-1:3], 3'b000};
            ds_q        <= next_delayslot;
            int_q       <= int_flag;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_ack) begin
            req_q       <= 1'b0;
            stall_req_q <= 1'b0;
            pc_q        <= next_pc;
            if (redir) begin
              state_q <= S_ISSUE;
            end else begin
              if_pc_q      <= pc_q;
              pair_q.inst1 <= pc_q[2] ? ibus_rdata[63:32] : ibus_rdata[31:0];
              pair_q.inst2 <= pc_q[2] ? 32'h0 : ibus_rdata[63:32];
              avail_q      <= ~pc_q[2];
              ds_out_q     <= ds_q & ~flush_seen_q;
              except_q     <= '0;
              intr_q       <= int_q;
              hard_q       <= first_q;
              first_q      <= 1'b0;
              flush_seen_q <= 1'b0;
              state_q      <= stall.stall_if ? S_HOLD : S_ISSUE;
            end
          end else if (redir) begin
            state_q <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc_q     <= next_pc;
            if_pc_q  <= '0;
            pair_q   <= '0;
            avail_q  <= 1'b0;
            ds_out_q <= 1'b0;
            except_q <= '0;
            intr_q   <= '0;
            state_q  <= S_ISSUE;
          end else if (!stall.stall_if) begin
            state_q <= S_ISSUE;
          end
        end
        S_DISCARD: begin
          if (ibus_ack) begin
            req_q       <= 1'b0;
            stall_req_q <= 1'b0;
            pc_q        <= next_pc;
            state_q     <= S_ISSUE;
          end
        end
        default: state_q <= S_ISSUE;
      endcase
      if (flush && state_q != S_RST) begin
        flush_seen_q <= 1'b1;
      end
    end
  end

  assign ibus_req          = req_q;
  assign ibus_addr         = addr_q;
  assign stall_req_if      = stall_req_q;
  assign if_pc             = if_pc_q;
  assign if_inst_pair      = pair_q;
  assign if_inst2_avail    = avail_q;
  assign if_delayslot      = ds_out_q;
  assign if_except         = except_q;
  assign if_interrupt_flag = intr_q;
  assign is_hard_reset     = hard_q;

endmodule
